// File: rtl/lsu_if.sv
// Word-wide data bus between the load/store unit (master) and memory (slave).
// Request side is stable for the whole REQ phase; read data returns after grant.
interface lsu_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one decoded memory op -> one word-bus transaction, with lane
// steering, load extension, misalignment detection and a saturating bus timeout.

module lsu_lane #(
   parameter int unsigned LANE = 0
) (
   input  logic [1:0] acc_i,
   input  logic [1:0] off_i,
   input  logic [7:0] b_byte_i,
   input  logic [7:0] b_half_i,
   input  logic [7:0] b_word_i,
   output logic       be_o,
   output logic [7:0] wbyte_o
);
   localparam logic [2:0] L = 3'(LANE);

   logic [2:0] off_x;
   assign off_x = {1'b0, off_i};

   // Enable matches 4'b0001<<off (byte) and 4'b0011<<off (half) for this lane.
   always_comb begin
      be_o    = 1'b1;
      wbyte_o = b_word_i;
      case (acc_i)
         2'b00: begin
            be_o    = (L == off_x);
            wbyte_o = b_byte_i;
         end
         2'b01: begin
            be_o    = (L == off_x) || (L == off_x + 3'd1);
            wbyte_o = b_half_i;
         end
         default: ;
      endcase
   end
endmodule

module lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        ld_en_i,
   input  logic        st_en_i,
   input  logic [1:0]  acc_i,
   input  logic        sext_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o,
   output logic        err_o,
   lsu_if.master       bus
);
   localparam int unsigned NUM_LANES = 4;
   localparam logic [9:0]  TMO       = 10'(TIMEOUT);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  acc_q, acc_d;
   logic        sext_q, sext_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        misalign_q, misalign_d;
   logic        err_q, err_d;

   logic [NUM_LANES-1:0]      be_w;
   logic [NUM_LANES-1:0][7:0] wlane_w;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      lsu_lane #(.LANE(l)) u_lane (
         .acc_i   (acc_i),
         .off_i   (addr_i[1:0]),
         .b_byte_i(wdata_i[7:0]),
         .b_half_i(wdata_i[8*(l%2) +: 8]),
         .b_word_i(wdata_i[8*l +: 8]),
         .be_o    (be_w[l]),
         .wbyte_o (wlane_w[l])
      );
   end

   logic req_w;
   logic illegal_w;
   assign req_w     = ld_en_i | st_en_i;
   assign illegal_w = (ld_en_i & st_en_i) | (acc_i == 2'b11)
                    | ((acc_i == 2'b01) & addr_i[0])
                    | ((acc_i == 2'b10) & (addr_i[1:0] != 2'b00));

   logic [31:0] lane_w;
   logic [31:0] rext_w;
   assign lane_w = bus.rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (acc_q)
         2'b00:   rext_w = {{24{sext_q & lane_w[7]}}, lane_w[7:0]};
         2'b01:   rext_w = {{16{sext_q & lane_w[15]}}, lane_w[15:0]};
         default: rext_w = lane_w;
      endcase
   end

   // Counter saturates at TMO, so a late grant into WAIT cannot wrap it.
   logic [9:0] cnt_inc_w;
   logic       tmo_w;
   assign cnt_inc_w = (cnt_q >= TMO) ? TMO : cnt_q + 10'd1;
   assign tmo_w     = (cnt_inc_w >= TMO);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      acc_d      = acc_q;
      sext_d     = sext_q;
      we_d       = we_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      misalign_d = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_w) begin
               addr_d  = addr_i;
               acc_d   = acc_i;
               sext_d  = sext_i;
               we_d    = st_en_i;
               be_d    = be_w;
               wdata_d = wlane_w;
               if (illegal_w) begin
                  misalign_d = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            cnt_d = cnt_inc_w;
            // Completion takes priority over a timeout in the same cycle.
            if (bus.gnt) begin
               state_d = we_q ? ST_DONE : ST_WAIT;
            end else if (tmo_w) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_inc_w;
            if (bus.rvalid) begin
               rdata_d = rext_w;
               state_d = ST_DONE;
            end else if (tmo_w) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         acc_q      <= '0;
         sext_q     <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         acc_q      <= acc_d;
         sext_q     <= sext_d;
         we_q       <= we_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
         err_q      <= err_d;
      end
   end

   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = (state_q == ST_DONE);
   assign rdata_o    = rdata_q;
   assign misalign_o = misalign_q;
   assign err_o      = err_q;

   assign bus.req   = (state_q == ST_REQ);
   assign bus.we    = we_q;
   assign bus.addr  = {addr_q[31:2], 2'b00};
   assign bus.be    = be_q;
   assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases plus randomized ops against a cycle-count model.
module tb_lsu;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        ld_en = 1'b0, st_en = 1'b0, sext = 1'b0;
   logic [1:0]  acc = 2'b00;
   logic [31:0] addr = '0, wdata = '0;
   logic        busy, done, mis, err;
   logic [31:0] rdata;

   lsu_if u_bus ();

   lsu #(.TIMEOUT(T)) dut (
      .clk_i(clk), .rstn_i(rstn), .ld_en_i(ld_en), .st_en_i(st_en),
      .acc_i(acc), .sext_i(sext), .addr_i(addr), .wdata_i(wdata),
      .busy_o(busy), .done_o(done), .rdata_o(rdata),
      .misalign_o(mis), .err_o(err), .bus(u_bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd_model = '0;

   // Drives one op and acts as bus slave: grant at REQ cycle gdly+1, data rdly
   // cycles after grant; junk adds stray rvalid in IDLE and on the grant cycle.
   task automatic op(input logic ld, st, input logic [1:0] ac, input logic sx,
                     input logic [31:0] a, wd, input int gdly, rdly,
                     input logic [31:0] rw, input logic junk,
                     output int lat, nreq, output logic [3:0] obe,
                     output logic [31:0] oaddr, owd, output logic owe,
                     output logic omis, oerr, req_at_done, hs_ok,
                     output logic [31:0] ord);
      int gc;
      @(negedge clk);
      ld_en = ld; st_en = st; acc = ac; sext = sx; addr = a; wdata = wd;
      if (junk) begin u_bus.rvalid = 1'b1; u_bus.rdata = ~rw; end
      @(posedge clk);
      lat = 0; nreq = 0; gc = -1; obe = '0; oaddr = '0; owd = '0; owe = 1'b0;
      omis = 1'b0; oerr = 1'b0; req_at_done = 1'b0; hs_ok = 1'b1; ord = '0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         @(negedge clk);
         ld_en = 1'b0; st_en = 1'b0; addr = $urandom; wdata = $urandom;
         acc = 2'($urandom); sext = 1'($urandom);
         u_bus.gnt = 1'b0; u_bus.rvalid = 1'b0; u_bus.rdata = $urandom;
         if (!busy) hs_ok = 1'b0;
         if (u_bus.req) begin
            nreq++;
            if (nreq == 1) begin
               obe = u_bus.be; oaddr = u_bus.addr; owd = u_bus.wdata; owe = u_bus.we;
            end
            if (nreq - 1 == gdly) begin
               u_bus.gnt = 1'b1; gc = c;
               if (junk) begin u_bus.rvalid = 1'b1; u_bus.rdata = ~rw; end
            end
         end
         if (gc > 0 && rdly > 0 && c == gc + rdly) begin
            u_bus.rvalid = 1'b1; u_bus.rdata = rw;
         end
         if (done) begin
            lat = c; omis = mis; oerr = err; ord = rdata; req_at_done = u_bus.req;
         end
      end
      @(negedge clk);
      u_bus.gnt = 1'b0; u_bus.rvalid = 1'b0;
      if (done || busy) hs_ok = 1'b0;
   endtask

   function automatic logic [31:0] ext(input logic [1:0] ac, input logic sx,
                                       input logic [1:0] off, input logic [31:0] rw);
      logic [31:0] sh;
      sh = rw >> (8 * off);
      if (ac == 2'b00) return sx ? 32'(int'($signed(sh[7:0])))  : 32'(sh[7:0]);
      if (ac == 2'b01) return sx ? 32'(int'($signed(sh[15:0]))) : 32'(sh[15:0]);
      return rw;
   endfunction

   task automatic test_reset;
      rstn = 1'b0;
      u_bus.gnt = 1'b0; u_bus.rvalid = 1'b0; u_bus.rdata = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, mis, err, u_bus.req, u_bus.we} !== 6'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 000000",
                            {busy, done, mis, err, u_bus.req, u_bus.we});
      end
      checks++;
      if ({rdata, u_bus.addr, u_bus.wdata, u_bus.be} !== 100'b0) begin
         errors++; $display("FAIL reset_data: got %h/%h/%h/%b expected zero",
                            rdata, u_bus.addr, u_bus.wdata, u_bus.be);
      end
      rstn = 1'b1;
      rd_model = '0;
   endtask

   task automatic test_store_byte;
      int lat, nreq; logic [3:0] be; logic [31:0] ba, bw, rd; logic we, m, e, rq, hs;
      op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 0, '0, 1'b0,
         lat, nreq, be, ba, bw, we, m, e, rq, hs, rd);
      checks++; if (be !== 4'b1000) begin errors++; $display("FAIL st_be: got %b expected 1000", be); end
      checks++; if (ba !== 32'h1000) begin errors++; $display("FAIL st_addr: got %h expected 00001000", ba); end
      checks++; if (bw !== 32'hA5A5_A5A5) begin errors++; $display("FAIL st_wdata: got %h expected a5a5a5a5", bw); end
      checks++; if (we !== 1'b1) begin errors++; $display("FAIL st_we: got %b expected 1", we); end
      checks++; if (lat != 2) begin errors++; $display("FAIL st_latency: got %0d expected 2", lat); end
      checks++; if ({m, e, hs} !== 3'b001) begin errors++; $display("FAIL st_flags: got mis/err/hs %b expected 001", {m, e, hs}); end
   endtask

   task automatic test_load_half;
      int lat, nreq; logic [3:0] be; logic [31:0] ba, bw, rd; logic we, m, e, rq, hs;
      logic [31:0] exp_rd [2];
      exp_rd[0] = 32'h0000_8001; exp_rd[1] = 32'hFFFF_8001;
      for (int s = 1; s >= 0; s--) begin
         op(1'b1, 1'b0, 2'b01, 1'(s), 32'h0000_2002, '0, 0, 1, 32'h8001_1234, 1'b0,
            lat, nreq, be, ba, bw, we, m, e, rq, hs, rd);
         checks++; if (rd !== exp_rd[s]) begin errors++; $display("FAIL ldh_rdata sext=%0d: got %h expected %h", s, rd, exp_rd[s]); end
         checks++; if (be !== 4'b1100) begin errors++; $display("FAIL ldh_be sext=%0d: got %b expected 1100", s, be); end
         checks++; if (lat != 3 || we !== 1'b0) begin errors++; $display("FAIL ldh_lat_we sext=%0d: got %0d/%b expected 3/0", s, lat, we); end
         rd_model = exp_rd[s];
      end
   endtask

   task automatic test_misalign;
      int lat, nreq; logic [3:0] be; logic [31:0] ba, bw, rd; logic we, m, e, rq, hs;
      op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_2001, '0, 0, 1, 32'h1234_5678, 1'b0,
         lat, nreq, be, ba, bw, we, m, e, rq, hs, rd);
      checks++; if (lat != 1 || m !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL mis_word: got lat %0d mis %b err %b expected 1 1 0", lat, m, e); end
      checks++; if (nreq != 0) begin errors++; $display("FAIL mis_word_req: got %0d req cycles expected 0", nreq); end
      checks++; if (rd !== rd_model) begin errors++; $display("FAIL mis_word_rdata: got %h expected %h", rd, rd_model); end
      op(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_3000, '0, 0, 1, '0, 1'b0,
         lat, nreq, be, ba, bw, we, m, e, rq, hs, rd);
      checks++; if (lat != 1 || m !== 1'b1 || nreq != 0) begin errors++; $display("FAIL both_en: got lat %0d mis %b req %0d expected 1 1 0", lat, m, nreq); end
   endtask

   task automatic test_timeout;
      int lat, nreq; logic [3:0] be; logic [31:0] ba, bw, rd; logic we, m, e, rq, hs;
      op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 99, 0, '0, 1'b0,
         lat, nreq, be, ba, bw, we, m, e, rq, hs, rd);
      checks++; if (nreq != T) begin errors++; $display("FAIL tmo_req_cycles: got %0d expected %0d", nreq, T); end
      checks++; if (lat != T + 1 || e !== 1'b1 || m !== 1'b0) begin errors++; $display("FAIL tmo_done: got lat %0d err %b mis %b expected %0d 1 0", lat, e, m, T + 1); end
      checks++; if (rq !== 1'b0) begin errors++; $display("FAIL tmo_req_in_done: got %b expected 0", rq); end
   endtask

   task automatic test_same_cycle_rvalid;
      int lat, nreq; logic [3:0] be; logic [31:0] ba, bw, rd; logic we, m, e, rq, hs;
      op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_5001, '0, 1, 2, 32'h0000_8000, 1'b1,
         lat, nreq, be, ba, bw, we, m, e, rq, hs, rd);
      checks++; if (rd !== 32'hFFFF_FF80 || lat != 5 || e !== 1'b0) begin
         errors++; $display("FAIL gnt_rvalid_same: got %h lat %0d err %b expected ffffff80 5 0", rd, lat, e);
      end
      rd_model = 32'hFFFF_FF80;
   endtask

   task automatic test_reset_mid_op;
      int lat, nreq; logic [3:0] be; logic [31:0] ba, bw, rd; logic we, m, e, rq, hs;
      @(negedge clk);
      ld_en = 1'b1; acc = 2'b01; sext = 1'b1; addr = 32'h0000_2002;
      @(negedge clk);
      ld_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      u_bus.gnt = 1'b1;
      @(negedge clk);
      u_bus.gnt = 1'b0;
      checks++; if (busy !== 1'b1 || u_bus.req !== 1'b0) begin errors++; $display("FAIL rst_wait_state: got busy %b req %b expected 1 0", busy, u_bus.req); end
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, mis, err, u_bus.req, u_bus.we, u_bus.be} !== 10'b0 || rdata !== rd_model && rdata !== '0) begin
         errors++; $display("FAIL rst_mid_op: got flags %b rdata %h expected zero", {busy, done, mis, err, u_bus.req, u_bus.we, u_bus.be}, rdata);
      end
      checks++; if (rdata !== 32'h0 || u_bus.addr !== 32'h0) begin errors++; $display("FAIL rst_mid_op_data: got %h/%h expected 0/0", rdata, u_bus.addr); end
      rstn = 1'b1; rd_model = '0;
      @(negedge clk);
      u_bus.rvalid = 1'b1; u_bus.rdata = 32'h8001_1234;
      repeat (2) @(negedge clk);
      u_bus.rvalid = 1'b0;
      checks++; if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL stale_rvalid: got done %b busy %b rdata %h expected 0 0 0", done, busy, rdata); end
      op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, '0, 0, 1, 32'h8001_1234, 1'b0,
         lat, nreq, be, ba, bw, we, m, e, rq, hs, rd);
      checks++; if (rd !== 32'h0000_8001 || lat != 3) begin errors++; $display("FAIL after_reset_op: got %h lat %0d expected 00008001 3", rd, lat); end
      rd_model = 32'h0000_8001;
   endtask

   task automatic test_random;
      int lat, nreq; logic [3:0] be; logic [31:0] ba, bw, rd; logic we, m, e, rq, hs;
      for (int i = 0; i < 150; i++) begin
         int r, gdly, rdly, kg, kr, e_lat, e_nreq;
         logic ld, st, sx, jk, legal, ok;
         logic [1:0] ac;
         logic [31:0] a, wd, rw, e_wd;
         logic [3:0] e_be;
         r = $urandom_range(0, 19);
         ld = (r < 9) || (r == 19); st = (r >= 9);
         ac = 2'($urandom_range(0, 3)); sx = 1'($urandom);
         a = $urandom; wd = $urandom; rw = $urandom; jk = 1'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            if (ac == 2'b01) a[0] = 1'b0;
            if (ac == 2'b10) a[1:0] = 2'b00;
         end
         gdly = $urandom_range(0, 5); rdly = $urandom_range(1, 3);
         if (ld && !st && gdly == T - 1) gdly = T + 1;
         op(ld, st, ac, sx, a, wd, gdly, rdly, rw, jk,
            lat, nreq, be, ba, bw, we, m, e, rq, hs, rd);
         legal = !(ld && st) && ac != 2'b11 && !(ac == 2'b01 && a[0]) && !(ac == 2'b10 && a[1:0] != 2'b00);
         kg = gdly + 1; kr = kg + rdly;
         ok = st ? (kg <= T) : (kg < T && kr <= T);
         e_lat = !legal ? 1 : !ok ? T + 1 : st ? kg + 1 : kr + 1;
         e_nreq = !legal ? 0 : (kg < T ? kg : T);
         e_be = (ac == 2'b00) ? (4'b0001 << a[1:0]) : (ac == 2'b01) ? (4'b0011 << a[1:0]) : 4'b1111;
         e_wd = (ac == 2'b00) ? {4{wd[7:0]}} : (ac == 2'b01) ? {2{wd[15:0]}} : wd;
         checks++; if (lat != e_lat || nreq != e_nreq) begin errors++; $display("FAIL rnd_timing op%0d: got lat %0d req %0d expected %0d %0d", i, lat, nreq, e_lat, e_nreq); end
         checks++; if (m !== !legal || e !== (legal && !ok) || hs !== 1'b1) begin errors++; $display("FAIL rnd_flags op%0d: got mis %b err %b hs %b expected %b %b 1", i, m, e, hs, !legal, legal && !ok); end
         if (legal) begin
            checks++;
            if (be !== e_be || ba !== {a[31:2], 2'b00} || we !== st || (st && bw !== e_wd)) begin
               errors++; $display("FAIL rnd_bus op%0d: got be %b addr %h we %b wd %h expected %b %h %b %h", i, be, ba, we, bw, e_be, {a[31:2], 2'b00}, st, e_wd);
            end
         end
         if (ld) begin
            if (legal && ok && !st) rd_model = ext(ac, sx, a[1:0], rw);
            checks++; if (rd !== rd_model) begin errors++; $display("FAIL rnd_rdata op%0d: got %h expected %h", i, rd, rd_model); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_byte();
      test_load_half();
      test_misalign();
      test_timeout();
      test_same_cycle_rvalid();
      test_reset_mid_op();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
